// File: rtl/mpm_port_initiator_if.sv
// mpm_port_initiator_if
// Bundles the command handshake, the raw memory port and the read-response
// handshake of one mpm_port_initiator instance.
//   slave  : the initiator's view (accepts commands, drives the memory port)
//   master : the environment's view (issues commands, models the memory,
//            consumes responses)
//
// Handshake rule for both req_* and rsp_*: a transfer happens on a rising
// clock edge where valid and ready are both high. The sender holds its
// payload stable while valid is high and not yet accepted; ready never
// depends combinationally on the other side's ready.
interface mpm_port_initiator_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // command channel
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;

    // memory port
    logic [AW-1:0]    mem_addr;
    logic             mem_en;
    logic [WIDTH-1:0] mem_d;
    logic [WIDTH-1:0] mem_q;

    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_q, rsp_ready,
        output req_ready, mem_addr, mem_en, mem_d, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_q, rsp_ready,
        input  req_ready, mem_addr, mem_en, mem_d, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mpm_port_initiator.sv
// mpm_port_initiator
// Request front end for one port of the multi-ported memory. Commands are
// taken over a valid/ready handshake, registered onto the memory port, and
// read data is collected from mem_q after RD_LATENCY cycles into a small
// response FIFO that is returned in request order.
//
// Read credits: every read in the issue register, in the latency shift
// register, or waiting in the FIFO holds one credit. New commands (reads and
// writes alike) are only accepted while fewer than RSP_DEPTH credits are
// held, so a read that reaches the tail of the shift register always finds
// a free FIFO slot.
//
// Optional feature (macro MPM_INIT_RAW_STALL_EN): a read to the address of
// the write accepted in the previous cycle is held off for one cycle so the
// memory's write-to-read visibility window is respected. Without the macro
// no hazard logic exists and the caller must space such accesses.
//
// RD_LATENCY legal range 1..4; RSP_DEPTH a power of two, at least 2.
module mpm_port_initiator #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,
    mpm_port_initiator_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(RSP_DEPTH);
    // wide enough for inflight + occupancy with any legal parameters
    localparam int CW = 16;

    // issue register: what the memory port sees this cycle
    logic [AW-1:0]         r_mem_addr;
    logic                  r_mem_en;
    logic [WIDTH-1:0]      r_mem_d;
    logic                  r_iss_rd;

    // one bit per cycle of read latency; bit RD_LATENCY-1 is the tail
    logic [RD_LATENCY-1:0] r_rd_pipe;

    // response FIFO
    logic [WIDTH-1:0]      r_fifo [RSP_DEPTH];
    logic [PW:0]           r_wr_ptr;
    logic [PW:0]           r_rd_ptr;

    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [PW:0]           w_occ;
    logic [CW-1:0]         w_inflight;
    logic [CW-1:0]         w_used;
    logic                  w_credit_ok;
    logic                  w_raw_hazard;
    logic                  w_req_ready;

    // FIFO status from the extra pointer MSB
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_occ   = r_wr_ptr - r_rd_ptr;

    assign w_push  = r_rd_pipe[RD_LATENCY-1];
    assign w_pop   = !w_empty && bus.rsp_ready;

    // count of reads issued but not yet written into the FIFO
    always_comb begin
        w_inflight = CW'(r_iss_rd);
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_rd_pipe[i]);
        end
    end

    // credit check uses registered state only, so a pop frees its credit
    // for the following cycle and rsp_ready never reaches req_ready
    always_comb begin
        w_used      = w_inflight + CW'(w_occ);
        w_credit_ok = (w_used < CW'(RSP_DEPTH));
    end

`ifdef MPM_INIT_RAW_STALL_EN
    // r_mem_en is high exactly when a write was accepted last cycle, and
    // r_mem_addr holds that write's address
    assign w_raw_hazard = r_mem_en && bus.req_valid && !bus.req_we &&
                          (bus.req_addr == r_mem_addr);
`else
    assign w_raw_hazard = 1'b0;
`endif

    // w_full is implied by the credit check; kept as a second guard
    assign w_req_ready = !rst && w_credit_ok && !w_full && !w_raw_hazard;
    assign w_accept    = bus.req_valid && w_req_ready;

    // issue register: load on accept, otherwise drive an idle port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_addr <= '0;
            r_mem_en   <= 1'b0;
            r_mem_d    <= '0;
            r_iss_rd   <= 1'b0;
        end else if (w_accept) begin
            r_mem_addr <= bus.req_addr;
            r_mem_en   <= bus.req_we;
            r_mem_d    <= bus.req_we ? bus.req_wdata : '0;
            r_iss_rd   <= !bus.req_we;
        end else begin
            r_mem_addr <= '0;
            r_mem_en   <= 1'b0;
            r_mem_d    <= '0;
            r_iss_rd   <= 1'b0;
        end
    end

    // read-latency tracker: a read on the port enters at bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= r_iss_rd;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_pipe[i] <= r_rd_pipe[i-1];
            end
        end
    end

    // FIFO storage: capture mem_q when a read reaches the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PW-1:0]] <= bus.mem_q;
        end
    end

    // FIFO pointers; push and pop in the same cycle both take effect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_d     = r_mem_d;
    assign bus.rsp_valid = !w_empty;
    assign bus.rsp_data  = r_fifo[r_rd_ptr[PW-1:0]];
endmodule

// File: tb/tb_mpm_port_initiator.sv
// tb_mpm_port_initiator
// Directed bench for mpm_port_initiator with a behavioural memory behind the
// port. Reads accepted by the driver push their expected data (from a shadow
// copy of the memory) into exp_q; a monitor pops and compares whenever a
// response is consumed. Inputs change 1ns after the rising edge, outputs are
// sampled on the falling edge. Honours MPM_INIT_RAW_STALL_EN.
`timescale 1ns/1ps
module tb_mpm_port_initiator;
    localparam int WIDTH      = 8;
    localparam int DEPTH      = 8;
    localparam int RD_LATENCY = 1;
    localparam int RSP_DEPTH  = 4;
    localparam int AW         = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mpm_port_initiator_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    mpm_port_initiator #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY), .RSP_DEPTH(RSP_DEPTH)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- memory model ----------------
    logic [WIDTH-1:0] mem_arr [DEPTH];
    logic [WIDTH-1:0] q_pipe  [RD_LATENCY];
    always @(posedge clk) begin
        if (bus.mem_en) mem_arr[bus.mem_addr] <= bus.mem_d;
        q_pipe[0] <= mem_arr[bus.mem_addr];
        for (int i = 1; i < RD_LATENCY; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign bus.mem_q = q_pipe[RD_LATENCY-1];

    // ---------------- scoreboard ----------------
    int checks    = 0;
    int failures  = 0;
    int rsp_count = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [WIDTH-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // monitor: every consumed response must match the oldest expected read
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            rsp_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=%0d required=none", bus.rsp_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_data", 32'(bus.rsp_data), 32'(mon_exp));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // one cycle: drive inputs after the edge, report whether the command is
    // taken at the next edge
    task automatic drive_cycle(input logic v, input logic we, input logic [AW-1:0] a,
                               input logic [WIDTH-1:0] d, input logic rr, output logic acc);
        @(posedge clk);
        #1;
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        @(negedge clk);
        acc = v && (bus.req_ready === 1'b1);
        if (acc) begin
            if (we) shadow[a] = d;
            else    exp_q.push_back(shadow[a]);
        end
    endtask

    task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                            input logic rr, output int stalls);
        logic acc;
        stalls = 0;
        drive_cycle(1'b1, we, a, d, rr, acc);
        while (!acc && stalls < 50) begin
            stalls++;
            drive_cycle(1'b1, we, a, d, rr, acc);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept addr=%0d", a);
        end
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, '0, '0, rr, acc);
    endtask

    task automatic wait_drain();
        logic acc;
        int n;
        n = 0;
        do begin
            drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
            n++;
        end while ((exp_q.size() != 0 || bus.rsp_valid === 1'b1) && n < 50);
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int st;
        int st_sum;
        int rc0;
        int unsigned t_acc;
        logic acc;

        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // reset held for 2 cycles
        repeat (2) begin
            @(negedge clk);
            check("rst_mem_en",    32'(bus.mem_en),    0);
            check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
            check("rst_req_ready", 32'(bus.req_ready), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(bus.req_ready), 1);

        // write 42 to 5, idle 2, read 5
        send_req(1'b1, 3'd5, 8'd42, 1'b1, st);
        check("wr_stalls", 32'(st), 0);
        idle(1, 1'b1);
        check("wr_port_en",   32'(bus.mem_en),   1);
        check("wr_port_addr", 32'(bus.mem_addr), 5);
        check("wr_port_d",    32'(bus.mem_d),    42);
        idle(1, 1'b1);
        check("idle_port_en",   32'(bus.mem_en),   0);
        check("idle_port_addr", 32'(bus.mem_addr), 0);
        send_req(1'b0, 3'd5, 8'd0, 1'b1, st);
        t_acc = cyc;
        idle(1, 1'b1);
        check("rd_port_en",   32'(bus.mem_en),   0);
        check("rd_port_addr", 32'(bus.mem_addr), 5);
        check("rd_port_d",    32'(bus.mem_d),    0);
        while (bus.rsp_valid !== 1'b1 && (cyc - t_acc) < 10) idle(1, 1'b1);
        check("rd_latency", cyc - t_acc, 3);
        check("rd_data_42", 32'(bus.rsp_data), 42);
        wait_drain();

        // preload 10..17, then 8 back-to-back reads
        for (int i = 0; i < DEPTH; i++) send_req(1'b1, AW'(i), WIDTH'(10 + i), 1'b1, st);
        st_sum = 0;
        for (int i = 0; i < DEPTH; i++) begin
            send_req(1'b0, AW'(i), '0, 1'b1, st);
            st_sum += st;
        end
        check("b2b_stalls", 32'(st_sum), 0);
        wait_drain();

        // backpressure: four credits, then one pop buys exactly one accept
        st_sum = 0;
        for (int i = 0; i < 4; i++) begin
            send_req(1'b0, AW'(i), '0, 1'b0, st);
            st_sum += st;
        end
        check("bp_first4_stalls", 32'(st_sum), 0);
        drive_cycle(1'b1, 1'b0, 3'd4, '0, 1'b0, acc);
        check("bp_stall_a", 32'(acc), 0);
        drive_cycle(1'b1, 1'b0, 3'd4, '0, 1'b0, acc);
        check("bp_stall_b", 32'(acc), 0);
        check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
        drive_cycle(1'b1, 1'b0, 3'd4, '0, 1'b1, acc);
        check("bp_pop_cycle", 32'(acc), 0);
        drive_cycle(1'b1, 1'b0, 3'd4, '0, 1'b0, acc);
        check("bp_one_accept", 32'(acc), 1);
        drive_cycle(1'b1, 1'b0, 3'd5, '0, 1'b0, acc);
        check("bp_stall_c", 32'(acc), 0);
        drive_cycle(1'b1, 1'b0, 3'd5, '0, 1'b0, acc);
        check("bp_stall_d", 32'(acc), 0);
        wait_drain();

        // reset with 2 reads in flight and 2 in the FIFO
        for (int i = 0; i < 4; i++) send_req(1'b0, AW'(i), '0, 1'b0, st);
        check("mid_rsp_valid_pre", 32'(bus.rsp_valid), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("mid_rst_mem_en",    32'(bus.mem_en),    0);
        check("mid_rst_mem_addr",  32'(bus.mem_addr),  0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rc0 = rsp_count;
        send_req(1'b0, 3'd6, '0, 1'b1, st);
        check("post_rst_stalls", 32'(st), 0);
        idle(8, 1'b1);
        check("post_rst_rsp_count", 32'(rsp_count - rc0), 1);

        // write 7 to 3, read 3 on the next cycle
        send_req(1'b1, 3'd3, 8'd7, 1'b1, st);
        drive_cycle(1'b1, 1'b0, 3'd3, '0, 1'b1, acc);
`ifdef MPM_INIT_RAW_STALL_EN
        check("raw_stall", 32'(acc), 0);
        drive_cycle(1'b1, 1'b0, 3'd3, '0, 1'b1, acc);
        check("raw_accept_after", 32'(acc), 1);
`else
        check("raw_no_stall", 32'(acc), 1);
`endif
        wait_drain();
        check("exp_q_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
